// File: rtl/tri_pkg.sv
// rtl/tri_pkg.sv - shared types, constants and helpers for tri_host_ctrl
package tri_pkg;

  typedef enum logic [2:0] {IDLE, V1, V2, V3, WAIT_B, RUN} state_t;

  localparam int COORD_W = 3;
  localparam int GRID    = 8;
  localparam int VTX_W   = 18;
  localparam int PIX_W   = 7;

  function automatic logic [2*COORD_W-1:0] pix_idx(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/tri_host_ctrl_if.sv
// rtl/tri_host_ctrl_if.sv - command, rasterizer and result signals of tri_host_ctrl
interface tri_host_ctrl_if;
  import tri_pkg::*;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [VTX_W-1:0]          cmd_vtx;
  logic                      nt;
  logic [COORD_W-1:0]        xi;
  logic [COORD_W-1:0]        yi;
  logic                      r_busy;
  logic                      r_po;
  logic [COORD_W-1:0]        r_xo;
  logic [COORD_W-1:0]        r_yo;
  logic [GRID*GRID-1:0]      bitmap;
  logic [PIX_W-1:0]          pix_cnt;
  logic                      dup;
  logic                      done;
  logic                      err;

  modport slave (
    input  cmd_valid, cmd_vtx, r_busy, r_po, r_xo, r_yo,
    output cmd_ready, nt, xi, yi, bitmap, pix_cnt, dup, done, err
  );

  modport master (
    output cmd_valid, cmd_vtx, r_busy, r_po, r_xo, r_yo,
    input  cmd_ready, nt, xi, yi, bitmap, pix_cnt, dup, done, err
  );

endinterface

// File: rtl/tri_bitmap_acc.sv
// rtl/tri_bitmap_acc.sv - 8x8 point occupancy map with duplicate flag and saturating count
module tri_bitmap_acc
  import tri_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 hit,
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  output logic [GRID*GRID-1:0] bitmap,
  output logic [PIX_W-1:0]     pix_cnt,
  output logic                 dup
);

  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(GRID*GRID);

  logic [2*COORD_W-1:0] idx;

  assign idx = pix_idx(x, y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitmap  <= '0;
      pix_cnt <= '0;
      dup     <= 1'b0;
    end else if (clr) begin
      bitmap  <= '0;
      pix_cnt <= '0;
      dup     <= 1'b0;
    end else if (hit) begin
      bitmap[idx] <= 1'b1;
      if (bitmap[idx])
        dup <= 1'b1;
      if (pix_cnt != PIX_MAX)
        pix_cnt <= pix_cnt + PIX_W'(1);
    end
  end

endmodule

// File: rtl/tri_host_ctrl.sv
// rtl/tri_host_ctrl.sv - serialises a triangle command onto the rasterizer vertex bus
// and collects the resulting point stream, reporting done or a timeout error.
module tri_host_ctrl
  import tri_pkg::*;
#(
  parameter int BUSY_TMO = 4,
  parameter int RUN_TMO  = 255,
  parameter int CW       = 8
) (
  input logic            clk,
  input logic            reset,
  tri_host_ctrl_if.slave bus
);

  state_t                 state;
  logic [4*COORD_W-1:0]   vtx_rest;
  logic [CW-1:0]          cnt;
  logic                   accept;
  logic                   hit;

  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign hit    = (state == RUN) & bus.r_po;

  // cmd_ready is held low for the done/err cycle so a new command lands one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b1;
      bus.nt        <= 1'b0;
      bus.xi        <= '0;
      bus.yi        <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      vtx_rest      <= '0;
      cnt           <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (accept) begin
            vtx_rest      <= bus.cmd_vtx[4*COORD_W-1:0];
            bus.cmd_ready <= 1'b0;
            bus.nt        <= 1'b1;
            bus.xi        <= bus.cmd_vtx[VTX_W-1 -: COORD_W];
            bus.yi        <= bus.cmd_vtx[VTX_W-COORD_W-1 -: COORD_W];
            state         <= V1;
          end
        end
        V1: begin
          bus.nt <= 1'b0;
          bus.xi <= vtx_rest[4*COORD_W-1 -: COORD_W];
          bus.yi <= vtx_rest[3*COORD_W-1 -: COORD_W];
          state  <= V2;
        end
        V2: begin
          bus.xi <= vtx_rest[2*COORD_W-1 -: COORD_W];
          bus.yi <= vtx_rest[COORD_W-1:0];
          state  <= V3;
        end
        V3: begin
          bus.xi <= '0;
          bus.yi <= '0;
          cnt    <= '0;
          state  <= WAIT_B;
        end
        WAIT_B: begin
          if (bus.r_busy) begin
            cnt   <= '0;
            state <= RUN;
          end else if (cnt == CW'(BUSY_TMO - 1)) begin
            bus.err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (!bus.r_busy) begin
            bus.done <= 1'b1;
            state    <= IDLE;
          end else if (cnt == CW'(RUN_TMO - 1)) begin
            bus.err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tri_bitmap_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .hit     (hit),
    .x       (bus.r_xo),
    .y       (bus.r_yo),
    .bitmap  (bus.bitmap),
    .pix_cnt (bus.pix_cnt),
    .dup     (bus.dup)
  );

endmodule

// File: tb/tb_tri_host_ctrl.sv
// tb/tb_tri_host_ctrl.sv - randomized self-checking bench for tri_host_ctrl
module tb_tri_host_ctrl;
  import tri_pkg::*;

  localparam int BUSY_TMO = 4;
  localparam int RUN_TMO  = 255;
  localparam int MAXT     = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  tri_host_ctrl_if bus();

  tri_host_ctrl #(.BUSY_TMO(BUSY_TMO), .RUN_TMO(RUN_TMO), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit         s_po [MAXT];
  logic [2:0] s_x  [MAXT];
  logic [2:0] s_y  [MAXT];
  logic [2:0] d_x  [4];
  logic [2:0] d_y  [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.cmd_valid = 1'b0;
    bus.r_busy    = 1'b0;
    bus.r_po      = 1'b0;
    bus.r_xo      = '0;
    bus.r_yo      = '0;
  endtask

  // t counts cycles from V1 (t=0); bd = WAIT_B cycle (1-based after V3) in which busy rises,
  // len = RUN cycles busy stays high after RUN entry; rst_at >= 0 aborts with reset at that t.
  task automatic run_trial(input logic [17:0] v, input int bd, input int len, input int po_pct,
                           input int dir_n, input int rst_at);
    int c, r, t_end, got_t, ecnt, idx;
    bit exp_err, ready_bad, edup, wide;
    logic [63:0] eb;
    logic [2:0] vx [3];
    logic [2:0] vy [3];
    vx[0] = v[17:15]; vy[0] = v[14:12];
    vx[1] = v[11:9];  vy[1] = v[8:6];
    vx[2] = v[5:3];   vy[2] = v[2:0];
    c = 2;
    r = c + bd + 1;
    if (bd > BUSY_TMO) begin
      exp_err = 1'b1; t_end = c + BUSY_TMO + 1;
    end else if (len >= RUN_TMO) begin
      exp_err = 1'b1; t_end = r + RUN_TMO;
    end else begin
      exp_err = 1'b0; t_end = r + len + 1;
    end
    wide = 1'($urandom_range(1));
    for (int t = 0; t <= t_end; t++) begin
      s_po[t] = ($urandom_range(99) < po_pct);
      s_x[t]  = wide ? 3'($urandom_range(7)) : 3'($urandom_range(1));
      s_y[t]  = wide ? 3'($urandom_range(7)) : 3'($urandom_range(1));
    end
    for (int i = 0; i < dir_n; i++) begin
      s_po[r+i] = 1'b1; s_x[r+i] = d_x[i]; s_y[r+i] = d_y[i];
    end
    eb = '0; ecnt = 0; edup = 1'b0;
    if (bd <= BUSY_TMO) begin
      for (int t = r; t < t_end; t++) begin
        if (s_po[t]) begin
          idx = int'(s_y[t]) * GRID + int'(s_x[t]);
          if (eb[idx]) edup = 1'b1;
          eb[idx] = 1'b1;
          if (ecnt < GRID * GRID) ecnt++;
        end
      end
    end

    @(negedge clk);
    check("ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_vtx   = v;
    got_t = -1;
    ready_bad = 1'b0;
    for (int t = 0; t <= t_end + 3; t++) begin
      @(negedge clk);
      if (t == 0) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_vtx   = 18'($urandom);
      end
      if (t < 3)
        check($sformatf("vtx%0d", t), {bus.nt, bus.xi, bus.yi}, {t == 0, vx[t], vy[t]});
      if (t == 3)
        check("vtx_clr", {bus.nt, bus.xi, bus.yi}, 0);
      if (bus.cmd_ready) ready_bad = 1'b1;
      if (bus.done || bus.err) begin
        got_t = t;
        check("end_kind", {bus.done, bus.err}, {~exp_err, exp_err});
      end
      if (t == rst_at) begin
        #2 reset = 1'b1;
        #1;
        check("rst_bitmap", bus.bitmap, 0);
        check("rst_outs", {bus.pix_cnt, bus.dup, bus.nt, bus.xi, bus.yi, bus.done, bus.err,
                           bus.cmd_ready}, 1);
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (got_t >= 0) break;
      bus.r_busy = (bd <= BUSY_TMO) && (t >= c + bd) && (t <= c + bd + len) && (t < t_end);
      bus.r_po   = s_po[t];
      bus.r_xo   = s_x[t];
      bus.r_yo   = s_y[t];
    end
    check("end_cycle", got_t, t_end);
    check("ready_busy", ready_bad, 0);
    bus.r_busy = 1'b0;
    bus.r_po   = 1'b1;
    bus.r_xo   = 3'($urandom_range(7));
    bus.r_yo   = 3'($urandom_range(7));
    @(negedge clk);
    check("pulse", {bus.done, bus.err}, 0);
    check("ready_after", bus.cmd_ready, 1);
    check("bitmap", bus.bitmap, eb);
    check("pix_cnt", bus.pix_cnt, ecnt);
    check("dup", bus.dup, edup);
    drive_idle();
  endtask

  initial begin
    logic [17:0] v;
    int bd;
    drive_idle();
    bus.cmd_vtx = '0;
    repeat (2) @(negedge clk);
    check("reset_bitmap", bus.bitmap, 0);
    check("reset_outs", {bus.pix_cnt, bus.dup, bus.nt, bus.xi, bus.yi, bus.done, bus.err,
                         bus.cmd_ready}, 1);
    reset = 1'b0;

    v = {3'd1, 3'd0, 3'd5, 3'd0, 3'd1, 3'd4};
    d_x[0] = 3'd0; d_y[0] = 3'd0;
    d_x[1] = 3'd1; d_y[1] = 3'd0;
    d_x[2] = 3'd0; d_y[2] = 3'd1;
    run_trial(v, 1, 2, 0, 3, -1);

    d_x[0] = 3'd2; d_y[0] = 3'd2;
    d_x[1] = 3'd2; d_y[1] = 3'd2;
    run_trial(18'($urandom), 2, 1, 0, 2, -1);

    run_trial(18'($urandom), BUSY_TMO + 1, 0, 50, 0, -1);
    run_trial(18'($urandom), BUSY_TMO, 5, 50, 0, -1);
    run_trial(18'($urandom), 3, 300, 30, 0, -1);
    run_trial(18'($urandom), 1, RUN_TMO - 1, 20, 0, -1);
    run_trial(18'($urandom), 1, RUN_TMO, 20, 0, -1);
    run_trial(18'($urandom), 2, 80, 100, 0, -1);

    run_trial(18'($urandom), 1, 10, 60, 0, 7);
    run_trial(v, 1, 6, 60, 0, -1);
    run_trial(18'($urandom), 1, 10, 60, 0, 0);
    run_trial(18'($urandom), 2, 4, 60, 0, -1);

    for (int i = 0; i < 25; i++) begin
      v  = 18'($urandom);
      bd = ($urandom_range(5) == 0) ? BUSY_TMO + 1 : int'($urandom_range(BUSY_TMO, 1));
      run_trial(v, bd, int'($urandom_range(30)), int'($urandom_range(100)), 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
